nems_cfg_driver: RTL and testbench



---
 rtl/nems_cfg_pkg.sv | 30 +++
 rtl/nems_cfg_driver_if.sv | 27 ++
 rtl/nems_cfg_phase_timer.sv | 24 ++
 rtl/nems_cfg_driver.sv | 124 ++++++++++++
 tb/tb_nems_cfg_driver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/nems_cfg_pkg.sv
// Shared types and default geometry/timing for the NEMS relay crossbar config driver.
package nems_cfg_pkg;

    localparam int unsigned NEMS_NUM_ROWS  = 30;
    localparam int unsigned NEMS_NUM_COLS  = 29;
    localparam int unsigned NEMS_SETUP_CYC = 4;
    localparam int unsigned NEMS_PULSE_CYC = 16;
    localparam int unsigned NEMS_HOLD_CYC  = 4;

    typedef enum logic [2:0] {
        SHIFT,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } nems_cfg_state_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nems_cfg_driver_if.sv
// Serial bitstream handshake plus relay row/column drive bundle for one CLB tile.
interface nems_cfg_driver_if
    import nems_cfg_pkg::*;
#(
    parameter int unsigned NUM_ROWS = NEMS_NUM_ROWS,
    parameter int unsigned NUM_COLS = NEMS_NUM_COLS
);
    logic                cfg_e;
    logic                cfg_i;
    logic                cfg_rdy;
    logic                cfg_o;
    logic                cfg_clr;
    logic [NUM_ROWS-1:0] cfgrows;
    logic [NUM_COLS-1:0] cfgcols;
    logic                cfg_busy;
    logic                cfg_done;

    modport master (
        output cfg_e, cfg_i, cfg_clr,
        input  cfg_rdy, cfg_o, cfgrows, cfgcols, cfg_busy, cfg_done
    );

    modport slave (
        input  cfg_e, cfg_i, cfg_clr,
        output cfg_rdy, cfg_o, cfgrows, cfgcols, cfg_busy, cfg_done
    );
endinterface

// File: rtl/nems_cfg_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module nems_cfg_phase_timer #(
    parameter int unsigned TW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          tc
);
    logic [TW-1:0] tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (load) begin
            tmr <= load_val;
        end else if (tmr != '0) begin
            tmr <= tmr - TW'(1);
        end
    end

    assign tc = (tmr == '0);
endmodule

// File: rtl/nems_cfg_driver.sv
// Shifts one column of row data in serially, then drives setup/strobe/hold on the
// relay crossbar for that column; the displaced scan bit chains to the next tile.
module nems_cfg_driver
    import nems_cfg_pkg::*;
#(
    parameter int unsigned NUM_ROWS  = NEMS_NUM_ROWS,
    parameter int unsigned NUM_COLS  = NEMS_NUM_COLS,
    parameter int unsigned SETUP_CYC = NEMS_SETUP_CYC,
    parameter int unsigned PULSE_CYC = NEMS_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = NEMS_HOLD_CYC
) (
    input  logic             cfg_clk,
    input  logic             cfg_rst_n,
    nems_cfg_driver_if.slave bus
);
    localparam int unsigned BW = idx_width(NUM_ROWS);
    localparam int unsigned CW = idx_width(NUM_COLS);
    localparam int unsigned TW = idx_width(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(NUM_COLS - 1);
    localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYC - 1);
    localparam logic [NUM_COLS-1:0] COL_ONE = {{(NUM_COLS-1){1'b0}}, 1'b1};

    nems_cfg_state_t     state;
    logic [BW-1:0]       bit_cnt;
    logic [CW-1:0]       col_idx;
    logic [NUM_ROWS-1:0] row_sr;
    logic [NUM_ROWS-1:0] row_sh;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_tc;

    assign row_sh = {row_sr[NUM_ROWS-2:0], bus.cfg_i};

    // Each phase preloads length-1 so the terminal-count cycle is the last cycle of the phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            SHIFT: if (bus.cfg_e && bit_cnt == LAST_BIT) begin
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            SETUP: if (tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = PULSE_LD;
            end
            PULSE: if (tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            default: ;
        endcase
    end

    nems_cfg_phase_timer #(.TW(TW)) u_timer (
        .clk      (cfg_clk),
        .rst_n    (cfg_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
        if (!cfg_rst_n) begin
            state        <= SHIFT;
            bit_cnt      <= '0;
            col_idx      <= '0;
            row_sr       <= '0;
            bus.cfgrows  <= '0;
            bus.cfgcols  <= '0;
            bus.cfg_o    <= 1'b0;
            bus.cfg_busy <= 1'b0;
            bus.cfg_done <= 1'b0;
            bus.cfg_rdy  <= 1'b1;
        end else begin
            case (state)
                SHIFT: if (bus.cfg_e) begin
                    row_sr    <= row_sh;
                    bus.cfg_o <= row_sr[NUM_ROWS-1];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt      <= '0;
                        bus.cfgrows  <= row_sh;
                        bus.cfg_rdy  <= 1'b0;
                        bus.cfg_busy <= 1'b1;
                        state        <= SETUP;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                SETUP: if (tmr_tc) begin
                    bus.cfgcols <= COL_ONE << col_idx;
                    state       <= PULSE;
                end
                PULSE: if (tmr_tc) begin
                    bus.cfgcols <= '0;
                    state       <= HOLD;
                end
                HOLD: if (tmr_tc) begin
                    bus.cfgrows  <= '0;
                    bus.cfg_busy <= 1'b0;
                    if (col_idx == LAST_COL) begin
                        bus.cfg_done <= 1'b1;
                        state        <= DONE;
                    end else begin
                        col_idx     <= col_idx + CW'(1);
                        bus.cfg_rdy <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                DONE: if (bus.cfg_clr) begin
                    col_idx      <= '0;
                    bus.cfg_done <= 1'b0;
                    bus.cfg_rdy  <= 1'b1;
                    state        <= SHIFT;
                end
                default: state <= SHIFT;
            endcase
        end
    end
endmodule

// File: tb/tb_nems_cfg_driver.sv
// Directed bench for nems_cfg_driver: per-column vector table plus hand-built
// sequences for backpressure, stall, chaining, async reset and DONE/clear.
module tb_nems_cfg_driver;
    import nems_cfg_pkg::*;

    localparam int unsigned NR = NEMS_NUM_ROWS;
    localparam int unsigned NC = NEMS_NUM_COLS;
    localparam int unsigned SC = NEMS_SETUP_CYC;
    localparam int unsigned PC = NEMS_PULSE_CYC;
    localparam int unsigned HC = NEMS_HOLD_CYC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nems_cfg_driver_if #(.NUM_ROWS(NR), .NUM_COLS(NC)) bus ();

    nems_cfg_driver #(
        .NUM_ROWS (NR),
        .NUM_COLS (NC),
        .SETUP_CYC(SC),
        .PULSE_CYC(PC),
        .HOLD_CYC (HC)
    ) dut (
        .cfg_clk  (clk),
        .cfg_rst_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [NR-1:0] data;
        logic [NC-1:0] cols;
    } vec_t;

    vec_t          tbl [NC];
    int            n_vec = 0;
    int            n_err = 0;
    int unsigned   cyc = 0;
    int unsigned   t_first = 0;
    logic [NR-1:0] mdl_sr;
    logic          mdl_o;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pack(input logic [NR-1:0] r, input logic [NC-1:0] c,
                                         input logic busy, input logic rdy,
                                         input logic done, input logic o);
        return 64'({r, c, busy, rdy, done, o});
    endfunction

    function automatic logic [63:0] obs();
        return pack(bus.cfgrows, bus.cfgcols, bus.cfg_busy, bus.cfg_rdy, bus.cfg_done, bus.cfg_o);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift one column MSB first; stall_at inserts 7 idle cycles before that bit.
    task automatic shift_col(input logic [NR-1:0] data, input int stall_at);
        for (int b = NR - 1; b >= 0; b--) begin
            if ((NR - 1 - b) == stall_at) begin
                for (int s = 0; s < 7; s++) begin
                    bus.cfg_e = 1'b0;
                    bus.cfg_i = s[0];
                    tick();
                    chk("stall", obs(), pack('0, '0, 1'b0, 1'b1, 1'b0, mdl_o));
                end
            end
            chk("shift_pre", obs(), pack('0, '0, 1'b0, 1'b1, 1'b0, mdl_o));
            bus.cfg_e = 1'b1;
            bus.cfg_i = data[b];
            tick();
            if (b == NR - 1) t_first = cyc;
            mdl_o  = mdl_sr[NR-1];
            mdl_sr = {mdl_sr[NR-2:0], data[b]};
            chk("cfg_o", 64'(bus.cfg_o), 64'(mdl_o));
        end
        bus.cfg_e = 1'b0;
    endtask

    task automatic phases(input logic [NR-1:0] rows, input logic [NC-1:0] cols,
                          input bit toggle, input bit clr_pulse, input bit last);
        for (int i = 0; i < SC; i++) begin
            chk("setup", obs(), pack(rows, '0, 1'b1, 1'b0, 1'b0, mdl_o));
            bus.cfg_e = toggle;
            bus.cfg_i = i[0];
            tick();
        end
        for (int i = 0; i < PC; i++) begin
            chk("pulse", obs(), pack(rows, cols, 1'b1, 1'b0, 1'b0, mdl_o));
            bus.cfg_e   = toggle;
            bus.cfg_i   = ~i[0];
            bus.cfg_clr = clr_pulse && (i == 5);
            tick();
        end
        bus.cfg_clr = 1'b0;
        for (int i = 0; i < HC; i++) begin
            chk("hold", obs(), pack(rows, '0, 1'b1, 1'b0, 1'b0, mdl_o));
            bus.cfg_e = toggle;
            bus.cfg_i = i[0];
            tick();
        end
        bus.cfg_e = 1'b0;
        chk("col_end", obs(), pack('0, '0, 1'b0, !last, last, mdl_o));
    endtask

    initial begin
        int unsigned t0;
        for (int unsigned i = 0; i < NC; i++) begin
            tbl[i].data = {6{i[4:0]}};
            tbl[i].cols = {{(NC-1){1'b0}}, 1'b1} << i;
        end
        bus.cfg_e   = 1'b0;
        bus.cfg_i   = 1'b0;
        bus.cfg_clr = 1'b0;
        mdl_sr      = '0;
        mdl_o       = 1'b0;

        repeat (2) tick();
        chk("reset", obs(), pack('0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();

        // Single column with backpressure: toggling cfg_e/cfg_i while busy.
        shift_col(30'h2AAAAAAA, -1);
        phases(30'h2AAAAAAA, 29'h1, 1'b1, 1'b0, 1'b0);
        // Stall mid-shift; cfg_o continues the chain from the previous column.
        shift_col(30'h0F0F0F0F, 12);
        phases(30'h0F0F0F0F, 29'h2, 1'b0, 1'b0, 1'b0);
        // cfg_clr during PULSE must not disturb the strobe.
        shift_col(30'h12345678, -1);
        phases(30'h12345678, 29'h4, 1'b0, 1'b1, 1'b0);

        // Async reset in the middle of PULSE, checked between clock edges.
        shift_col(30'h3FFFFFFF, -1);
        repeat (SC + 5) tick();
        chk("mid_pulse", obs(), pack(30'h3FFFFFFF, 29'h8, 1'b1, 1'b0, 1'b0, mdl_o));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", obs(), pack('0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
        mdl_sr = '0;
        mdl_o  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Full array from the vector table.
        t0 = 0;
        for (int unsigned i = 0; i < NC; i++) begin
            shift_col(tbl[i].data, -1);
            if (i == 0) t0 = t_first;
            phases(tbl[i].data, tbl[i].cols, 1'b0, 1'b0, i == NC - 1);
        end
        chk("done_latency", 64'(cyc - t0 + 1), 64'd1566);

        for (int k = 0; k < 3; k++) begin
            bus.cfg_e = 1'b1;
            bus.cfg_i = k[0];
            tick();
            chk("done_hold", obs(), pack('0, '0, 1'b0, 1'b0, 1'b1, mdl_o));
        end
        bus.cfg_e   = 1'b0;
        bus.cfg_clr = 1'b1;
        tick();
        bus.cfg_clr = 1'b0;
        chk("clr", obs(), pack('0, '0, 1'b0, 1'b1, 1'b0, mdl_o));
        shift_col(30'h15555555, -1);
        phases(30'h15555555, 29'h1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
